// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
// Optional host requester is enabled by defining MEM_ARBITER_HOST_EN.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DATA  = 2'd1,
    HOST  = 2'd2
  } req_id_t;

  localparam int DEF_MEM_LAT    = 1;
  localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner selection: host > starved fetch > data > fetch.
// The host input exists only when MEM_ARBITER_HOST_EN is defined.
module mem_arb_select
  import mem_arbiter_pkg::*;
#(
  parameter int SW         = 3,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic          f_req,
  input  logic          d_req,
`ifdef MEM_ARBITER_HOST_EN
  input  logic          h_req,
`endif
  input  logic [SW-1:0] starve_cnt,
  output logic          grant_valid,
  output req_id_t       grant_id
);

  // priority chain; fetch overtakes data once it has waited STARVE_MAX grants
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = FETCH;
`ifdef MEM_ARBITER_HOST_EN
    if (h_req) begin
      grant_valid = 1'b1;
      grant_id    = HOST;
    end else
`endif
    if (f_req && (starve_cnt == SW'(STARVE_MAX))) begin
      grant_valid = 1'b1;
      grant_id    = FETCH;
    end else if (d_req) begin
      grant_valid = 1'b1;
      grant_id    = DATA;
    end else if (f_req) begin
      grant_valid = 1'b1;
      grant_id    = FETCH;
    end else begin
      grant_valid = 1'b0;
      grant_id    = FETCH;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requesters onto one memory port.
// Define MEM_ARBITER_HOST_EN to add a highest-priority host requester (h_*).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef MEM_ARBITER_HOST_EN
  ,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_ack,
  output logic [DW-1:0] h_rdata
`endif
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int LW = 3;

  state_t        state_r, state_nxt_s;
  req_id_t       id_r, id_nxt_s;
  logic          we_r, we_nxt_s;
  logic [AW-1:0] addr_r, addr_nxt_s;
  logic [DW-1:0] wdata_r, wdata_nxt_s;
  logic [LW-1:0] lat_r, lat_nxt_s;
  logic [SW-1:0] starve_r, starve_nxt_s;
  logic [DW-1:0] rdata_r;
  logic          cap_s, done_s, acc_nxt_s;
  logic          grant_valid_s;
  req_id_t       grant_id_s;

  mem_arb_select #(
    .SW         (SW),
    .STARVE_MAX (STARVE_MAX)
  ) u_select (
    .f_req       (f_req),
    .d_req       (d_req),
`ifdef MEM_ARBITER_HOST_EN
    .h_req       (h_req),
`endif
    .starve_cnt  (starve_r),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // next-state, latch and starve-counter logic
  always_comb begin
    state_nxt_s  = state_r;
    id_nxt_s     = id_r;
    we_nxt_s     = we_r;
    addr_nxt_s   = addr_r;
    wdata_nxt_s  = wdata_r;
    lat_nxt_s    = lat_r;
    starve_nxt_s = starve_r;
    cap_s        = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        lat_nxt_s = {LW{1'b0}};
        if (grant_valid_s) begin
          state_nxt_s = ACCESS;
          id_nxt_s    = grant_id_s;
          case (grant_id_s)
            DATA: begin
              we_nxt_s    = d_we;
              addr_nxt_s  = d_addr;
              wdata_nxt_s = d_wdata;
            end
`ifdef MEM_ARBITER_HOST_EN
            HOST: begin
              we_nxt_s    = h_we;
              addr_nxt_s  = h_addr;
              wdata_nxt_s = h_wdata;
            end
`endif
            default: begin
              we_nxt_s    = 1'b0;
              addr_nxt_s  = f_addr;
              wdata_nxt_s = {DW{1'b0}};
            end
          endcase
        end else begin
          state_nxt_s = IDLE;
        end
        // host grants leave the counter alone; only fetch/data affect it
        if (grant_valid_s && (grant_id_s == FETCH)) begin
          starve_nxt_s = {SW{1'b0}};
        end else if (!f_req) begin
          starve_nxt_s = {SW{1'b0}};
        end else if (grant_valid_s && (grant_id_s == DATA) &&
                     (starve_r != SW'(STARVE_MAX))) begin
          starve_nxt_s = starve_r + SW'(1);
        end else begin
          starve_nxt_s = starve_r;
        end
      end
      ACCESS: begin
        if (lat_r == LW'(MEM_LAT - 1)) begin
          state_nxt_s = RESP;
          cap_s       = 1'b1;
        end else begin
          lat_nxt_s = lat_r + LW'(1);
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
        done_s      = 1'b1;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign acc_nxt_s = (state_nxt_s == ACCESS);

  // state, latched request and registered outputs (memory port follows next state)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      id_r      <= FETCH;
      we_r      <= 1'b0;
      addr_r    <= {AW{1'b0}};
      wdata_r   <= {DW{1'b0}};
      lat_r     <= {LW{1'b0}};
      starve_r  <= {SW{1'b0}};
      rdata_r   <= {DW{1'b0}};
      mem_en    <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= {AW{1'b0}};
      mem_wdata <= {DW{1'b0}};
      busy      <= 1'b0;
      f_ack     <= 1'b0;
      d_ack     <= 1'b0;
      f_rdata   <= {DW{1'b0}};
      d_rdata   <= {DW{1'b0}};
`ifdef MEM_ARBITER_HOST_EN
      h_ack     <= 1'b0;
      h_rdata   <= {DW{1'b0}};
`endif
    end else begin
      state_r   <= state_nxt_s;
      id_r      <= id_nxt_s;
      we_r      <= we_nxt_s;
      addr_r    <= addr_nxt_s;
      wdata_r   <= wdata_nxt_s;
      lat_r     <= lat_nxt_s;
      starve_r  <= starve_nxt_s;
      if (cap_s) rdata_r <= mem_rdata;
      mem_en    <= acc_nxt_s;
      mem_wen   <= acc_nxt_s & we_nxt_s;
      mem_addr  <= acc_nxt_s ? addr_nxt_s : {AW{1'b0}};
      mem_wdata <= acc_nxt_s ? wdata_nxt_s : {DW{1'b0}};
      busy      <= (state_nxt_s != IDLE);
      f_ack     <= done_s && (id_r == FETCH);
      d_ack     <= done_s && (id_r == DATA);
      if (done_s && (id_r == FETCH)) f_rdata <= rdata_r;
      if (done_s && (id_r == DATA))  d_rdata <= we_r ? {DW{1'b0}} : rdata_r;
`ifdef MEM_ARBITER_HOST_EN
      h_ack     <= done_s && (id_r == HOST);
      if (done_s && (id_r == HOST))  h_rdata <= we_r ? {DW{1'b0}} : rdata_r;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT 1 and 3) share stimulus and
// are checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int SMAX = 4;

  bit          clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] f_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0, mem_rdata = 32'h0;

  logic        f_ack [2], d_ack [2], mem_en [2], mem_wen [2], busy [2];
  logic [31:0] f_rdata [2], d_rdata [2], mem_addr [2], mem_wdata [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) u0 (
    .clk(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack[0]),
    .f_rdata(f_rdata[0]), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
    .mem_en(mem_en[0]), .mem_wen(mem_wen[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata), .busy(busy[0]));

  mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(SMAX)) u1 (
    .clk(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack[1]),
    .f_rdata(f_rdata[1]), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
    .mem_en(mem_en[1]), .mem_wen(mem_wen[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata), .busy(busy[1]));

  // Reference model: one in-flight transaction per instance, tracked by age
  // (edges since its grant); the memory is busy for lat edges, acked lat+1 later.
  int          lat [2] = '{1, 3};
  bit          m_act [2], m_we [2], e_fack [2], e_dack [2];
  int          m_age [2], m_id [2], m_starve [2];
  logic [31:0] m_addr [2], m_wdata [2], m_capt [2], e_frd [2], e_drd [2];

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int w;
      w = -1;
      e_fack[k] = 1'b0;
      e_dack[k] = 1'b0;
      if (rst) begin
        m_act[k] = 1'b0; m_age[k] = 0; m_starve[k] = 0; m_id[k] = 0; m_we[k] = 1'b0;
        m_addr[k] = 32'h0; m_wdata[k] = 32'h0; m_capt[k] = 32'h0;
        e_frd[k] = 32'h0; e_drd[k] = 32'h0;
      end else if (!m_act[k]) begin
        if (f_req && m_starve[k] == SMAX) w = 0;
        else if (d_req) w = 1;
        else if (f_req) w = 0;
        if (w == 0 || !f_req) m_starve[k] = 0;
        else if (w == 1) m_starve[k] = (m_starve[k] + 1 > SMAX) ? SMAX : m_starve[k] + 1;
        if (w >= 0) begin
          m_act[k] = 1'b1; m_age[k] = 0; m_id[k] = w;
          m_we[k] = (w == 1) ? d_we : 1'b0;
          m_addr[k] = (w == 1) ? d_addr : f_addr;
          m_wdata[k] = (w == 1) ? d_wdata : 32'h0;
        end
      end else begin
        m_age[k]++;
        if (m_age[k] == lat[k]) m_capt[k] = mem_rdata;
        if (m_age[k] == lat[k] + 1) begin
          m_act[k] = 1'b0;
          if (m_id[k] == 0) begin
            e_fack[k] = 1'b1; e_frd[k] = m_capt[k];
          end else begin
            e_dack[k] = 1'b1; e_drd[k] = m_we[k] ? 32'h0 : m_capt[k];
          end
        end
      end
    end
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d t=%0t got %h expected %h", name, k, $time, got, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      bit en;
      en = m_act[k] && (m_age[k] < lat[k]);
      chk("mem_en", k, 32'(mem_en[k]), 32'(en));
      chk("mem_wen", k, 32'(mem_wen[k]), 32'(en & m_we[k]));
      chk("mem_addr", k, mem_addr[k], en ? m_addr[k] : 32'h0);
      chk("mem_wdata", k, mem_wdata[k], en ? m_wdata[k] : 32'h0);
      chk("busy", k, 32'(busy[k]), 32'(m_act[k]));
      chk("f_ack", k, 32'(f_ack[k]), 32'(e_fack[k]));
      chk("d_ack", k, 32'(d_ack[k]), 32'(e_dack[k]));
      chk("f_rdata", k, f_rdata[k], e_frd[k]);
      chk("d_rdata", k, d_rdata[k], e_drd[k]);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    bit          f, d, we;
    logic [31:0] fa, da, wd, rd;
    bit          exp_f_first;
    logic [31:0] exp_rdata;
    int          lat0, lat1;
  } vec_t;

  vec_t        tbl [4];
  int          first [2], en_cnt [2], t_d, t_f;
  bit          was_f [2];
  logic [31:0] got_rd [2];
  byte         seq [2][$];
  string       pat = "DDDDFDDDDF";

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0,  32'h0,  32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 3, 5};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 32'h0,  32'h24, 32'h0,  32'h12345678, 1'b0, 32'h12345678, 3, 5};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h0,  32'h20, 32'h55, 32'hAAAA5555, 1'b0, 32'h00000000, 3, 5};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h40, 32'h44, 32'h0,  32'h0BADF00D, 1'b0, 32'h0BADF00D, 3, 5};

    // reset state
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();

    // single-transaction vectors
    for (int v = 0; v < 4; v++) begin
      f_req = tbl[v].f; d_req = tbl[v].d; d_we = tbl[v].we;
      f_addr = tbl[v].fa; d_addr = tbl[v].da; d_wdata = tbl[v].wd; mem_rdata = tbl[v].rd;
      for (int k = 0; k < 2; k++) begin first[k] = -1; en_cnt[k] = 0; got_rd[k] = 32'h0; was_f[k] = 1'b0; end
      for (int n = 1; n <= 12; n++) begin
        cycle();
        for (int k = 0; k < 2; k++) begin
          if (mem_en[k]) en_cnt[k]++;
          if (first[k] < 0 && (f_ack[k] || d_ack[k])) begin
            first[k] = n; was_f[k] = f_ack[k]; got_rd[k] = f_ack[k] ? f_rdata[k] : d_rdata[k];
          end
        end
        if (first[0] == n) begin f_req = 1'b0; d_req = 1'b0; end
      end
      chk("vec_lat", 0, first[0], tbl[v].lat0);
      chk("vec_lat", 1, first[1], tbl[v].lat1);
      for (int k = 0; k < 2; k++) begin
        chk("vec_winner_is_fetch", k, 32'(was_f[k]), 32'(tbl[v].exp_f_first));
        chk("vec_rdata", k, got_rd[k], tbl[v].exp_rdata);
        chk("vec_mem_en_cycles", k, en_cnt[k], lat[k]);
      end
    end

    // simultaneous data write and fetch: data first, fetch 3 cycles later
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55; f_addr = 32'h80;
    t_d = -1; t_f = -1;
    for (int n = 1; n <= 20; n++) begin
      cycle();
      if (n == 1) begin
        chk("first_grant_wen", 0, 32'(mem_wen[0]), 32'h1);
        chk("first_grant_addr", 0, mem_addr[0], 32'h20);
      end
      if (d_ack[0] && t_d < 0) begin t_d = n; d_req = 1'b0; end
      if (f_ack[0] && t_f < 0) begin t_f = n; f_req = 1'b0; end
    end
    chk("d_ack_time", 0, t_d, 3);
    chk("f_after_d", 0, t_f - t_d, 3);
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    for (int n = 0; n < 8; n++) cycle();

    // starvation: both held continuously
    f_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    for (int n = 0; n < 60; n++) begin
      cycle();
      for (int k = 0; k < 2; k++) begin
        if (d_ack[k]) seq[k].push_back("D");
        if (f_ack[k]) seq[k].push_back("F");
      end
    end
    for (int k = 0; k < 2; k++) begin
      chk("starve_ack_count_ok", k, 32'(seq[k].size() >= 10), 32'h1);
      for (int i = 0; i < 10 && i < seq[k].size(); i++)
        chk("starve_pattern", k, 32'(seq[k][i]), 32'(pat[i]));
    end
    f_req = 1'b0; d_req = 1'b0;
    for (int n = 0; n < 8; n++) cycle();

    // reset in the middle of an access
    f_req = 1'b1; f_addr = 32'h90; mem_rdata = 32'hCAFEF00D;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    for (int k = 0; k < 2; k++) begin
      chk("rst_mem_en", k, 32'(mem_en[k]), 32'h0);
      chk("rst_busy", k, 32'(busy[k]), 32'h0);
      chk("rst_no_ack", k, 32'(f_ack[k] | d_ack[k]), 32'h0);
    end
    rst = 1'b0;
    cycle();
    for (int k = 0; k < 2; k++) chk("post_rst_grant", k, 32'(mem_en[k]), 32'h1);
    t_f = -1;
    for (int n = 2; n <= 10; n++) begin
      cycle();
      if (f_ack[0] && t_f < 0) t_f = n;
    end
    chk("post_rst_ack_time", 0, t_f, 3);
    f_req = 1'b0;
    for (int n = 0; n < 8; n++) cycle();

    // randomized traffic
    for (int n = 0; n < 500; n++) begin
      f_req = ($urandom_range(0, 3) != 0);
      d_req = ($urandom_range(0, 2) != 0);
      d_we = $urandom_range(0, 1) == 1;
      f_addr = $urandom();
      d_addr = $urandom();
      d_wdata = $urandom();
      mem_rdata = $urandom();
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 32, address width in bits.
REQ-002 Parameter DW, 32, data width in bits.
REQ-003 Parameter MEM_LAT, 1, memory read/write latency in cycles; legal range 1-7.
REQ-004 Parameter STARVE_MAX, 4, maximum consecutive data grants while a fetch is pending.
REQ-005 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 f_req  in  1  instruction-fetch request; f_addr  in  AW  fetch address.
REQ-008 f_ack  out  1  one-cycle completion pulse; f_rdata  out  DW  fetched word, valid with f_ack.
REQ-009 d_req  in  1  data request; d_we  in  1  write when 1; d_addr  in  AW; d_wdata  in  DW.
REQ-010 d_ack  out  1  one-cycle completion pulse; d_rdata  out  DW  read word, valid with d_ack.
REQ-011 mem_en  out  1; mem_wen  out  1; mem_addr  out  AW; mem_wdata  out  DW  shared memory port.
REQ-012 mem_rdata  in  DW  memory read data.
REQ-013 busy  out  1  high whenever the state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-015 IDLE: if any request is high, the arbiter SHALL select a winner, latch its address, write data and write flag, and enter ACCESS on the next edge.
REQ-016 Priority SHALL be data over fetch, except that fetch SHALL win once the starve counter equals STARVE_MAX and f_req is high.
REQ-017 The starve counter SHALL increment on each data grant made while f_req is high, SHALL clear on any fetch grant or whenever f_req is low in IDLE, and SHALL saturate at STARVE_MAX.
REQ-018 ACCESS: mem_en SHALL be 1 and mem_wen SHALL equal the latched write flag (0 for fetch) for exactly MEM_LAT cycles; mem_addr and mem_wdata SHALL be driven from the latched values.
REQ-019 mem_rdata SHALL be captured on the last ACCESS cycle; the state then moves to RESP.
REQ-020 RESP: exactly one ack (for the granted requester) SHALL pulse for one cycle with its rdata; the next state is IDLE.
REQ-021 Latency from a request sampled in IDLE to its ack SHALL be MEM_LAT+2 cycles; the minimum gap between consecutive grants is MEM_LAT+2 cycles.
REQ-022 A requester SHALL hold req until its ack; a request dropped after a grant SHALL NOT abort the access, and the ack SHALL still be issued.
REQ-023 A write ack SHALL drive d_rdata to 0.
REQ-024 When not in ACCESS, mem_en, mem_wen, mem_addr and mem_wdata SHALL all be 0.
REQ-025 f_rdata and d_rdata SHALL hold their last captured value between acks.

Reset
REQ-026 rst SHALL force IDLE, clear the starve counter, the latched fields and both rdata registers, and drive all acks, mem_* outputs and busy to 0 on the next edge.
REQ-027 An rst asserted mid-ACCESS SHALL abort the access with no ack issued; the first grant SHALL be possible on the cycle after rst deasserts.

Configuration
REQ-028 Macro MEM_ARBITER_HOST_EN: when defined, the module SHALL add a third requester with ports h_req, h_we, h_addr, h_wdata, h_ack and h_rdata, which has priority over both data and starvation-forced fetch grants and never touches the starve counter.
REQ-029 When MEM_ARBITER_HOST_EN is not defined, the h_* ports SHALL NOT exist and the module SHALL behave as REQ-014 to REQ-027 describe.

Structure
REQ-030 A shared package SHALL hold the FSM state enumeration (IDLE, ACCESS, RESP), the requester-ID encoding (FETCH, DATA, HOST) and the default MEM_LAT and STARVE_MAX constants.
REQ-031 The priority and starvation selection SHALL be a combinational sub-module named mem_arb_select; the FSM and the latency counter stay in mem_arbiter.

Verification
REQ-032 MEM_LAT=1; f_req alone, f_addr=0x10, mem_rdata=0xDEADBEEF -> mem_en high for 1 cycle, f_ack at cycle 3, f_rdata=0xDEADBEEF.
REQ-033 f_req and d_req rise together; d_we=1, d_addr=0x20, d_wdata=0x55 -> data granted first (mem_wen=1, mem_addr=0x20), then fetch; d_ack precedes f_ack by 3 cycles.
REQ-034 STARVE_MAX=4; d_req and f_req held continuously -> exactly 4 data acks, then 1 fetch ack, and the pattern repeats.
REQ-035 MEM_LAT=3 -> mem_en high for exactly 3 cycles; ack arrives 5 cycles after the request.
REQ-036 rst pulsed on the second ACCESS cycle -> no ack, mem_en=0 and busy=0 on the next edge; a held request is granted after rst deasserts.
REQ-037 With MEM_ARBITER_HOST_EN, all three requests rise together -> h_ack first, then d_ack, then f_ack.
